// File: rtl/i2s_rx_framer_if.sv
// i2s_rx_framer_if
// Bundles the raw I2S lines with the framed stereo output of i2s_rx_framer.
// The master side is the framer: it consumes BCK/LRCK/SD and drives the
// frame bus; the slave side is the I2S source plus the downstream consumer.
interface i2s_rx_framer_if #(
  parameter int W = 32
);
  logic           bck_in;
  logic           lrck_in;
  logic           sd_in;
  logic [2*W-1:0] data;
  logic           start;
  logic           err;
  logic           locked;

  modport master (
    input  bck_in,
    input  lrck_in,
    input  sd_in,
    output data,
    output start,
    output err,
    output locked
  );

  modport slave (
    output bck_in,
    output lrck_in,
    output sd_in,
    input  data,
    input  start,
    input  err,
    input  locked
  );
endinterface

// File: rtl/i2s_rx_framer.sv
// i2s_rx_framer
// Upstream feeder for the NOS DAC transceiver. Synchronizes an asynchronous
// I2S stream, deserializes one stereo frame and presents {left, right} on
// data with a one-cycle start strobe. Slot-length errors pulse err and drop
// lock; a BCK watchdog drops lock when the bit clock stops.
// Build option: define I2S_RX_LJ_EN for left-justified input (MSB aligned
// with the LRCK edge, no 1-bit delay). Without it, standard I2S is expected.
module i2s_rx_framer #(
  parameter int W       = 32,   // matches I2S_BITS in the common package
  parameter int TIMEOUT = 1024
) (
  input logic             clk,
  input logic             resetn,
  i2s_rx_framer_if.master bus
);

  localparam int CW = $clog2(W + 2);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t         state;
  logic [2:0]     bck_sync;
  logic [2:0]     lrck_sync;
  logic [2:0]     sd_sync;
  logic           rise;
  logic           rise_q;
  logic [W-1:0]   shift_reg;
  logic [CW-1:0]  bit_cnt;
  logic           lrck_prev;
  logic [WW-1:0]  wd_cnt;
  logic [W-1:0]   hold_left;
  logic           left_ok;
  logic [2*W-1:0] data_q;
  logic           start_q;
  logic           err_q;
  logic           locked_q;

  logic           lrck_s;
  logic           sd_s;
  logic [CW-1:0]  bit_cnt_inc;
  logic           boundary;
  logic [W-1:0]   closing_word;
  logic [CW-1:0]  closing_cnt;
  logic [CW-1:0]  restart_cnt;
  logic           word_good;
  logic           wd_expired;

  // Three-stage synchronizers on all I2S lines; BCK rise is detected between stages 2 and 3
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      sd_sync   <= '0;
    end else begin
      bck_sync  <= {bck_sync[1:0], bus.bck_in};
      lrck_sync <= {lrck_sync[1:0], bus.lrck_in};
      sd_sync   <= {sd_sync[1:0], bus.sd_in};
    end
  end

  assign rise = bck_sync[1] & ~bck_sync[2];

  // Register the rise so the frame logic acts one cycle later; stage 3 of lrck/sd then holds the stage-2 values of the rise cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= rise;
    end
  end

  assign lrck_s = lrck_sync[2];
  assign sd_s   = sd_sync[2];

  // Slot-closing word and length, which differ between standard I2S and left-justified input
  always_comb begin
    bit_cnt_inc  = (bit_cnt == CW'(W + 1)) ? bit_cnt : bit_cnt + CW'(1);
    boundary     = rise_q && (lrck_s != lrck_prev);
`ifdef I2S_RX_LJ_EN
    closing_word = shift_reg;
    closing_cnt  = bit_cnt;
    restart_cnt  = CW'(1);
`else
    closing_word = {shift_reg[W-2:0], sd_s};
    closing_cnt  = bit_cnt_inc;
    restart_cnt  = '0;
`endif
    word_good    = (closing_cnt == CW'(W));
    wd_expired   = !rise_q && (wd_cnt == WW'(TIMEOUT - 1));
  end

  // Frame FSM: shifts bits, evaluates slots at LRCK changes, runs the BCK watchdog and registers all outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= HUNT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      lrck_prev <= 1'b0;
      wd_cnt    <= '0;
      hold_left <= '0;
      left_ok   <= 1'b0;
      data_q    <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      if (rise_q) begin
        wd_cnt    <= '0;
        shift_reg <= {shift_reg[W-2:0], sd_s};
        lrck_prev <= lrck_s;
        if (boundary) begin
          bit_cnt <= restart_cnt;
          case (state)
            HUNT: begin
              state <= RUN;
            end
            RUN: begin
              if (word_good) begin
                if (!lrck_prev) begin
                  hold_left <= closing_word;
                  left_ok   <= 1'b1;
                end else if (left_ok) begin
                  data_q   <= {hold_left, closing_word};
                  start_q  <= 1'b1;
                  locked_q <= 1'b1;
                  left_ok  <= 1'b0;
                end
              end else begin
                err_q    <= 1'b1;
                left_ok  <= 1'b0;
                locked_q <= 1'b0;
              end
            end
            default: begin
              state <= HUNT;
            end
          endcase
        end else begin
          bit_cnt <= bit_cnt_inc;
        end
      end else if (wd_expired) begin
        state    <= HUNT;
        locked_q <= 1'b0;
        left_ok  <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end

  assign bus.data   = data_q;
  assign bus.start  = start_q;
  assign bus.err    = err_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_i2s_rx_framer.sv
// tb_i2s_rx_framer
// Directed bench for i2s_rx_framer at W=32, BCK = clk/8. Expected frames are
// queued when the closing BCK rise is driven and popped when start fires,
// together with the clk cycle on which start must appear.
// Build with I2S_RX_LJ_EN defined to exercise the left-justified variant.
module tb_i2s_rx_framer;

  localparam int W       = 32;
  localparam int TIMEOUT = 1024;

  typedef struct {
    logic [2*W-1:0] data;
    int             cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  i2s_rx_framer_if #(.W(W)) bus ();

  i2s_rx_framer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  exp_t           exp_q[$];
  exp_t           mon_e;
  int             n_checks   = 0;
  int             n_fail     = 0;
  int             cyc_cnt    = 0;
  int             start_seen = 0;
  int             err_seen   = 0;
  logic           lrck_last;
  logic           pend_valid;
  logic [2*W-1:0] pend_data;
  logic [W-1:0]   tmp_word;

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Count clk rising edges so start latency can be checked in cycles
  always @(posedge clk) cyc_cnt++;

  task automatic check_output(input string name, input logic [2*W-1:0] got,
                              input logic [2*W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every start must match the head of the scoreboard, in data and in timing
  always @(negedge clk) begin
    if (bus.err === 1'b1) err_seen++;
    if (bus.start === 1'b1) begin
      start_seen++;
      check_output("start_err_exclusive", 64'(bus.err), 64'(0));
      check_output("start_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_output("frame_data", bus.data, mon_e.data);
        check_output("start_latency", 64'(cyc_cnt), 64'(mon_e.cyc));
      end
    end
  end

  // One BCK period: 4 clk low with lrck/sd set up, then 4 clk high
  task automatic send_bit(input logic lr, input logic b);
    bus.bck_in  = 1'b0;
    bus.lrck_in = lr;
    bus.sd_in   = b;
    repeat (4) @(negedge clk);
    bus.bck_in = 1'b1;
    if ((lr != lrck_last) && pend_valid) begin
      exp_q.push_back('{data: pend_data, cyc: cyc_cnt + 4});
      pend_valid = 1'b0;
    end
    lrck_last = lr;
    repeat (4) @(negedge clk);
  endtask

  // One slot of nbits, MSB first; arms the scoreboard for the LRCK change that closes it
  task automatic send_slot(input logic [W-1:0] word, input int nbits, input logic chan,
                           input logic expect_out, input logic [2*W-1:0] exp_data);
`ifdef I2S_RX_LJ_EN
    for (int i = nbits - 1; i >= 0; i--) send_bit(chan, word[i]);
    if (expect_out) begin
      pend_valid = 1'b1;
      pend_data  = exp_data;
    end
`else
    if (expect_out) begin
      pend_valid = 1'b1;
      pend_data  = exp_data;
    end
    for (int i = nbits - 1; i >= 0; i--) send_bit((i == 0) ? ~chan : chan, word[i]);
`endif
  endtask

  task automatic apply_stimulus(input logic [W-1:0] l, input logic [W-1:0] r,
                                input logic expect_out);
    send_slot(l, W, 1'b0, 1'b0, '0);
    send_slot(r, W, 1'b1, expect_out, {l, r});
  endtask

  // Directed sequence
  initial begin
    resetn      = 1'b0;
    bus.bck_in  = 1'b0;
    bus.lrck_in = 1'b0;
    bus.sd_in   = 1'b0;
    lrck_last   = 1'b0;
    pend_valid  = 1'b0;
    pend_data   = '0;
    repeat (4) @(negedge clk);
    check_output("reset_data", bus.data, '0);
    check_output("reset_start", 64'(bus.start), 64'(0));
    check_output("reset_err", 64'(bus.err), 64'(0));
    check_output("reset_locked", 64'(bus.locked), 64'(0));
    resetn = 1'b1;

`ifdef I2S_RX_LJ_EN
    $display("[TB] left-justified stream");
    apply_stimulus(32'h11111111, 32'h22222222, 1'b0);
    apply_stimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    send_slot(32'h0, W, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check_output("lj_start_count", 64'(start_seen), 64'(1));
    check_output("lj_data", bus.data, 64'hA5A5A5A5_5A5A5A5A);
    check_output("lj_locked", 64'(bus.locked), 64'(1));
    check_output("lj_err_count", 64'(err_seen), 64'(0));
    check_output("lj_queue_empty", 64'(exp_q.size()), 64'(0));
`else
    $display("[TB] three frames after reset, first pair dropped");
    apply_stimulus(32'h11111111, 32'h22222222, 1'b0);
    apply_stimulus(32'h12345678, 32'h9ABCDEF0, 1'b1);
    apply_stimulus(32'hFFFFFFFF, 32'h00000001, 1'b1);
    repeat (2) @(negedge clk);
    check_output("basic_start_count", 64'(start_seen), 64'(2));
    check_output("basic_data", bus.data, 64'hFFFFFFFF_00000001);
    check_output("basic_locked", 64'(bus.locked), 64'(1));
    check_output("basic_err_count", 64'(err_seen), 64'(0));

    $display("[TB] short left slot");
    send_slot(32'h07654321, 31, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check_output("short_err_count", 64'(err_seen), 64'(1));
    check_output("short_locked", 64'(bus.locked), 64'(0));
    send_slot(32'hCAFEF00D, W, 1'b1, 1'b0, '0);
    apply_stimulus(32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    repeat (2) @(negedge clk);
    check_output("recover_start_count", 64'(start_seen), 64'(3));
    check_output("recover_locked", 64'(bus.locked), 64'(1));
    check_output("recover_err_count", 64'(err_seen), 64'(1));

    $display("[TB] BCK stopped");
    repeat (1000) @(negedge clk);
    check_output("idle_still_locked", 64'(bus.locked), 64'(1));
    repeat (100) @(negedge clk);
    check_output("timeout_locked", 64'(bus.locked), 64'(0));
    check_output("timeout_data_held", bus.data, 64'hDEADBEEF_0BADF00D);
    check_output("timeout_no_err", 64'(err_seen), 64'(1));
    apply_stimulus(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    apply_stimulus(32'h13579BDF, 32'h2468ACE0, 1'b1);
    repeat (2) @(negedge clk);
    check_output("resume_start_count", 64'(start_seen), 64'(4));
    check_output("resume_locked", 64'(bus.locked), 64'(1));

    $display("[TB] reset mid right slot");
    send_slot(32'hAAAA5555, W, 1'b0, 1'b0, '0);
    tmp_word = 32'hC3C3C3C3;
    for (int i = W - 1; i >= W - 10; i--) send_bit(1'b1, tmp_word[i]);
    resetn      = 1'b0;
    bus.bck_in  = 1'b0;
    bus.lrck_in = 1'b0;
    bus.sd_in   = 1'b0;
    lrck_last   = 1'b0;
    pend_valid  = 1'b0;
    #1;
    check_output("midreset_data", bus.data, '0);
    check_output("midreset_locked", 64'(bus.locked), 64'(0));
    check_output("midreset_start", 64'(bus.start), 64'(0));
    check_output("midreset_err", 64'(bus.err), 64'(0));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(32'h11112222, 32'h33334444, 1'b0);
    apply_stimulus(32'h55556666, 32'h77778888, 1'b1);
    repeat (2) @(negedge clk);
    check_output("after_reset_start_count", 64'(start_seen), 64'(5));
    check_output("after_reset_err_count", 64'(err_seen), 64'(1));
    check_output("queue_empty", 64'(exp_q.size()), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
